// File: rtl/common_pkg.sv
// Shared core types plus register-file defaults and port structs.
package common;

    localparam int XLEN_DEF   = 64;
    localparam int NREG_DEF   = 32;
    localparam int NREAD_DEF  = 2;
    localparam int NWRITE_DEF = 2;
    localparam int CREG_AW    = $clog2(NREG_DEF);

    typedef logic [CREG_AW-1:0] creg_addr_t;
    typedef logic [63:0]        u64;

    typedef struct packed {
        creg_addr_t addr;
    } rf_rport_t;

    typedef struct packed {
        logic       valid;
        creg_addr_t addr;
        u64         data;
    } rf_wport_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write busy bitmap: priority flush > set > clear > hold, plus registered busy count.
module regfile_scoreboard
    import common::*;
#(
    parameter int NREG   = NREG_DEF,
    parameter int NWRITE = NWRITE_DEF,
    parameter int AW     = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NWRITE-1:0] wvalid,
    input  logic [NWRITE*AW-1:0] wa,
    input  logic              iss_valid,
    input  logic [AW-1:0]     iss_rd,
    input  logic              flush,
    output logic [NREG-1:0]   busy,
    output logic [NREG-1:0]   busy_post,
    output logic [AW:0]       busy_cnt
);

    logic [NREG-1:0] set_hit;
    logic [NREG-1:0] clr_hit;
    logic [NREG-1:0] busy_nxt;
    logic [AW:0]     cnt_nxt;

    always_comb begin
        set_hit   = '0;
        clr_hit   = '0;
        busy_nxt  = '0;
        busy_post = '0;
        cnt_nxt   = '0;
        for (int r = 1; r < NREG; r++) begin
            set_hit[r] = iss_valid && (iss_rd == AW'(r));
            for (int p = 0; p < NWRITE; p++) begin
                if (wvalid[p] && (wa[p*AW +: AW] == AW'(r)))
                    clr_hit[r] = 1'b1;
            end
            if (flush)
                busy_nxt[r] = 1'b0;
            else if (set_hit[r])
                busy_nxt[r] = 1'b1;
            else if (clr_hit[r])
                busy_nxt[r] = 1'b0;
            else
                busy_nxt[r] = busy[r];
            // Post-write view for bypassed reads: a clearing write drops busy unless a new producer lands too.
            busy_post[r] = busy[r] && !(clr_hit[r] && !set_hit[r]);
            cnt_nxt = cnt_nxt + (AW+1)'(busy_nxt[r]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with pending-write scoreboard.
// Optional REGFILE_BYPASS_EN: reads see same-cycle writes and post-write busy state.
module regfile_mp
    import common::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREG   = NREG_DEF,
    parameter int NREAD  = NREAD_DEF,
    parameter int NWRITE = NWRITE_DEF,
    parameter int AW     = $clog2(NREG)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREAD*AW-1:0]    ra,
    output logic [NREAD*XLEN-1:0]  rd,
    output logic [NREAD-1:0]       rbusy,
    input  logic [NWRITE-1:0]      wvalid,
    input  logic [NWRITE*AW-1:0]   wa,
    input  logic [NWRITE*XLEN-1:0] wd,
    input  logic                   iss_valid,
    input  logic [AW-1:0]          iss_rd,
    input  logic                   flush,
    output logic [AW:0]            busy_cnt
);

    logic [XLEN-1:0] regs   [NREG];
    logic [XLEN-1:0] wr_data[NREG];
    logic [NREG-1:0] wr_en;
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_post;

    regfile_scoreboard #(
        .NREG   (NREG),
        .NWRITE (NWRITE),
        .AW     (AW)
    ) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .wvalid    (wvalid),
        .wa        (wa),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .flush     (flush),
        .busy      (busy),
        .busy_post (busy_post),
        .busy_cnt  (busy_cnt)
    );

    // Ascending port scan so the youngest (highest-index) matching port wins.
    always_comb begin
        wr_en = '0;
        for (int r = 0; r < NREG; r++) begin
            wr_data[r] = '0;
            for (int p = 0; p < NWRITE; p++) begin
                if (r != 0 && wvalid[p] && (wa[p*AW +: AW] == AW'(r))) begin
                    wr_en[r]   = 1'b1;
                    wr_data[r] = wd[p*XLEN +: XLEN];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++)
                regs[r] <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (wr_en[r])
                    regs[r] <= wr_data[r];
            end
        end
    end

    always_comb begin
        rd    = '0;
        rbusy = '0;
        for (int i = 0; i < NREAD; i++) begin
            logic [AW-1:0] a;
            a = ra[i*AW +: AW];
            if (a != '0) begin
`ifdef REGFILE_BYPASS_EN
                rd[i*XLEN +: XLEN] = wr_en[a] ? wr_data[a] : regs[a];
                rbusy[i]           = busy_post[a];
`else
                rd[i*XLEN +: XLEN] = regs[a];
                rbusy[i]           = busy[a];
`endif
            end
        end
    end

`ifndef REGFILE_BYPASS_EN
    logic unused_post;
    assign unused_post = ^busy_post;
`endif

endmodule
